m_ir_encoder: RTL and testbench

- Instruction-word encoder: accepts MIPS instruction fields (R-, I- or J-format), packs them into 32-bit words, buffers them and writes them sequentially into instruction memory.
- Inverse of the field-extraction decode stage. Used by the bench/loader side to build program images that the decode stage then consumes.
- Valid/ready input handshake, small FIFO, write port with memory backpressure, end-of-program drain and done flag.

---
 rtl/m_ir_encoder_if.sv | 39 +++
 rtl/m_ir_encoder.sv | 116 +++++++++++
 tb/tb_m_ir_encoder.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_ir_encoder_if.sv
// Port bundle for m_ir_encoder: instruction-field input handshake, instruction-memory
// write port and status outputs.
interface m_ir_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              w_in_valid;
    logic              w_in_ready;
    logic [1:0]        w_fmt;
    logic [5:0]        w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [4:0]        w_shamt;
    logic [5:0]        w_funct;
    logic [15:0]       w_imm;
    logic [25:0]       w_target;
    logic              w_in_last;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [31:0]       w_mem_wdata;
    logic              w_mem_ready;
    logic              w_err;
    logic              w_done;
    logic [ADDR_W:0]   w_count;

    // Encoder side.
    modport slave (
        input  w_in_valid, w_fmt, w_op, w_rs, w_rt, w_rd, w_shamt, w_funct, w_imm,
               w_target, w_in_last, w_mem_ready,
        output w_in_ready, w_mem_we, w_mem_addr, w_mem_wdata, w_err, w_done, w_count
    );

    // Field source / memory side.
    modport master (
        output w_in_valid, w_fmt, w_op, w_rs, w_rt, w_rd, w_shamt, w_funct, w_imm,
               w_target, w_in_last, w_mem_ready,
        input  w_in_ready, w_mem_we, w_mem_addr, w_mem_wdata, w_err, w_done, w_count
    );
endinterface

// File: rtl/m_ir_encoder.sv
// MIPS instruction encoder: packs R/I/J field sets into 32-bit words, buffers them in a
// small FIFO and writes them to sequential instruction-memory addresses.
module m_ir_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic          w_clk,
    input  logic          w_rst,
    m_ir_encoder_if.slave bus
);
    localparam int unsigned       PtrW     = $clog2(DEPTH);
    localparam int unsigned       CntW     = PtrW + 1;
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CountMax = '1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       fifo_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   occ_q, occ_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;

    logic        open_st;
    logic        in_ready;
    logic        accept;
    logic        reserved;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic [31:0] word;

    always_comb begin
        word = '0;
        case (bus.w_fmt)
            2'b00:   word = {bus.w_op, bus.w_rs, bus.w_rt, bus.w_rd, bus.w_shamt, bus.w_funct};
            2'b01:   word = {bus.w_op, bus.w_rs, bus.w_rt, bus.w_imm};
            2'b10:   word = {bus.w_op, bus.w_target};
            default: word = '0;
        endcase
    end

    assign open_st    = (state_q == StIdle) || (state_q == StRun);
    // Gate with reset so the source sees no ready while reset is held.
    assign in_ready   = open_st && (occ_q < CntW'(DEPTH)) && !w_rst;
    assign accept     = bus.w_in_valid && in_ready;
    assign reserved   = (bus.w_fmt == 2'b11);
    assign push       = accept && !reserved;
    assign fifo_empty = (occ_q == '0);
    assign pop        = !fifo_empty && bus.w_mem_ready;

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + CntW'(1);
            2'b01:   occ_d = occ_q - CntW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) state_d = bus.w_in_last ? StDrain : StRun;
            end
            StRun: begin
                if (accept && bus.w_in_last) state_d = StDrain;
            end
            StDrain: begin
                if (fifo_empty || (occ_q == CntW'(1) && pop)) state_d = StDone;
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            addr_q   <= BaseAddr;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (accept && reserved) err_q <= 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
                // Address wraps to zero, not back to the base address.
                addr_q   <= addr_q + ADDR_W'(1);
                if (count_q != CountMax) count_q <= count_q + (ADDR_W + 1)'(1);
            end
        end
    end

    // Storage needs no reset: the occupancy count decides what is visible.
    always_ff @(posedge w_clk) begin
        if (push) fifo_q[wr_ptr_q] <= word;
    end

    assign bus.w_in_ready  = in_ready;
    assign bus.w_mem_we    = !fifo_empty;
    assign bus.w_mem_wdata = fifo_empty ? 32'h0 : fifo_q[rd_ptr_q];
    assign bus.w_mem_addr  = addr_q;
    assign bus.w_err       = err_q;
    assign bus.w_done      = (state_q == StDone);
    assign bus.w_count     = count_q;
endmodule

// File: tb/tb_m_ir_encoder.sv
// Self-checking bench for m_ir_encoder: vector table, directed corner sequences and a
// randomized run, all checked against a queue-based model of the encoder's rules.
module tb_m_ir_encoder;
  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  logic w_clk = 1'b0;
  logic w_rst = 1'b1;
  always #5 w_clk = ~w_clk;

  m_ir_encoder_if #(.ADDR_W(8)) bus0 ();
  m_ir_encoder_if #(.ADDR_W(2)) bus1 ();

  m_ir_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .w_clk(w_clk), .w_rst(w_rst), .bus(bus0));
  m_ir_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(2)) dut1 (
    .w_clk(w_clk), .w_rst(w_rst), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Model: per-DUT word queue (ring indices), address, count and status flags.
  logic [31:0] m_buf [2][64];
  int m_head [2];
  int m_tail [2];
  int m_addr [2];
  int m_count [2];
  bit m_closed [2];
  bit m_err [2];
  bit m_done [2];
  int base_a [2] = '{0, 2};
  int mask_a [2] = '{255, 3};
  int cmax [2] = '{511, 7};

  logic [31:0] cap_data [2][32];
  int cap_addr [2][32];
  int cap_cyc [2][32];
  int cap_n [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [1:0] f, input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] w;
    w = 32'(op) << 26;
    if (f == 2'd0)
      w = w + (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11) + (32'(sh) << 6) + 32'(fn);
    else if (f == 2'd1)
      w = w + (32'(rs) << 21) + (32'(rt) << 16) + 32'(imm);
    else
      w = w + 32'(tgt);
    return w;
  endfunction

  function automatic vec_t mk(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] imm, input logic [25:0] tgt, input logic [31:0] e);
    vec_t v;
    v.fmt = f; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh;
    v.fn = fn; v.imm = imm; v.tgt = tgt; v.exp = e;
    return v;
  endfunction

  function automatic vec_t mk_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [15:0] imm);
    return mk(2'd1, op, rs, rt, 5'd0, 5'd0, 6'd0, imm, 26'd0,
              enc(2'd1, op, rs, rt, 5'd0, 5'd0, 6'd0, imm, 26'd0));
  endfunction

  task automatic model_reset(input int d);
    m_head[d] = 0; m_tail[d] = 0; m_addr[d] = base_a[d]; m_count[d] = 0;
    m_closed[d] = 0; m_err[d] = 0; m_done[d] = 0; cap_n[d] = 0;
  endtask

  // Called once per negedge: compare outputs with the model, then advance the model to
  // the state after the coming rising edge.
  task automatic mon(input int d, input logic v, input logic rdy, input logic we,
      input logic mr, input logic [1:0] fmt, input logic [31:0] word, input logic last,
      input logic [31:0] wdata, input int addr, input logic err, input logic done,
      input int count);
    int size;
    bit pop;
    bit acc;
    if (w_rst) begin
      model_reset(d);
      chk($sformatf("d%0d_rst_in_ready", d), rdy, 0);
      chk($sformatf("d%0d_rst_we", d), we, 0);
      chk($sformatf("d%0d_rst_wdata", d), wdata, 0);
      chk($sformatf("d%0d_rst_addr", d), addr, base_a[d]);
      chk($sformatf("d%0d_rst_err_done", d), {err, done}, 0);
      chk($sformatf("d%0d_rst_count", d), count, 0);
      return;
    end
    size = m_tail[d] - m_head[d];
    chk($sformatf("d%0d_in_ready", d), rdy, !m_closed[d] && size < 4);
    chk($sformatf("d%0d_mem_we", d), we, size > 0);
    if (size > 0) begin
      chk($sformatf("d%0d_wdata", d), wdata, m_buf[d][m_head[d] % 64]);
      chk($sformatf("d%0d_addr", d), addr, m_addr[d]);
    end
    chk($sformatf("d%0d_err", d), err, m_err[d]);
    chk($sformatf("d%0d_done", d), done, m_done[d]);
    chk($sformatf("d%0d_count", d), count, m_count[d]);
    pop = (size > 0) && mr;
    acc = v && !m_closed[d] && size < 4;
    if (m_closed[d] && (size - int'(pop)) == 0) m_done[d] = 1;
    if (pop) begin
      m_head[d]++;
      m_addr[d] = (m_addr[d] + 1) & mask_a[d];
      if (m_count[d] < cmax[d]) m_count[d]++;
    end
    if (acc) begin
      if (fmt == 2'b11) m_err[d] = 1;
      else begin
        m_buf[d][m_tail[d] % 64] = word;
        m_tail[d]++;
      end
      if (last) m_closed[d] = 1;
    end
  endtask

  initial forever @(posedge w_clk) cyc++;

  initial forever begin
    @(negedge w_clk);
    if (!w_rst && bus0.w_mem_we && bus0.w_mem_ready) begin
      if (cap_n[0] < 32) begin
        cap_data[0][cap_n[0]] = bus0.w_mem_wdata;
        cap_addr[0][cap_n[0]] = int'(bus0.w_mem_addr);
        cap_cyc[0][cap_n[0]] = cyc;
      end
      cap_n[0]++;
    end
    if (!w_rst && bus1.w_mem_we && bus1.w_mem_ready) begin
      if (cap_n[1] < 32) begin
        cap_data[1][cap_n[1]] = bus1.w_mem_wdata;
        cap_addr[1][cap_n[1]] = int'(bus1.w_mem_addr);
        cap_cyc[1][cap_n[1]] = cyc;
      end
      cap_n[1]++;
    end
    mon(0, bus0.w_in_valid, bus0.w_in_ready, bus0.w_mem_we, bus0.w_mem_ready, bus0.w_fmt,
        enc(bus0.w_fmt, bus0.w_op, bus0.w_rs, bus0.w_rt, bus0.w_rd, bus0.w_shamt,
            bus0.w_funct, bus0.w_imm, bus0.w_target),
        bus0.w_in_last, bus0.w_mem_wdata, int'(bus0.w_mem_addr), bus0.w_err, bus0.w_done,
        int'(bus0.w_count));
    mon(1, bus1.w_in_valid, bus1.w_in_ready, bus1.w_mem_we, bus1.w_mem_ready, bus1.w_fmt,
        enc(bus1.w_fmt, bus1.w_op, bus1.w_rs, bus1.w_rt, bus1.w_rd, bus1.w_shamt,
            bus1.w_funct, bus1.w_imm, bus1.w_target),
        bus1.w_in_last, bus1.w_mem_wdata, int'(bus1.w_mem_addr), bus1.w_err, bus1.w_done,
        int'(bus1.w_count));
  end

  task automatic drive(input int d, input vec_t v, input logic last, input logic valid);
    if (d == 0) begin
      bus0.w_in_valid = valid; bus0.w_fmt = v.fmt; bus0.w_op = v.op; bus0.w_rs = v.rs;
      bus0.w_rt = v.rt; bus0.w_rd = v.rd; bus0.w_shamt = v.sh; bus0.w_funct = v.fn;
      bus0.w_imm = v.imm; bus0.w_target = v.tgt; bus0.w_in_last = last;
    end else begin
      bus1.w_in_valid = valid; bus1.w_fmt = v.fmt; bus1.w_op = v.op; bus1.w_rs = v.rs;
      bus1.w_rt = v.rt; bus1.w_rd = v.rd; bus1.w_shamt = v.sh; bus1.w_funct = v.fn;
      bus1.w_imm = v.imm; bus1.w_target = v.tgt; bus1.w_in_last = last;
    end
  endtask

  // Present a beat and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send(input int d, input vec_t v, input logic last);
    bit got;
    vec_t z;
    got = 0;
    z = mk(2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'd0);
    drive(d, v, last, 1'b1);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge w_clk);
      if ((d == 0) ? bus0.w_in_ready : bus1.w_in_ready) begin
        @(posedge w_clk);
        #1;
        got = 1;
      end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    drive(d, z, 1'b0, 1'b0);
  endtask

  task automatic wait_done(input int d, input int limit, input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge w_clk);
      seen = (d == 0) ? bus0.w_done : bus1.w_done;
    end
    chk(nm, seen, 1);
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    repeat (2) @(posedge w_clk);
    #1 w_rst = 1'b0;
  endtask

  vec_t vt [7];
  vec_t zv;
  int acc_n;
  int nres;
  bit any_res;
  bit stop;
  logic [31:0] w0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = mk(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hffff, 26'h3ffffff, 32'h00221820);
    vt[1] = mk(2'd2, 6'h02, 5'h1f, 5'h1f, 5'h1f, 5'h1f, 6'h3f, 16'hffff, 26'h0000010,
               32'h08000010);
    vt[2] = mk(2'd1, 6'h23, 5'd29, 5'd8, 5'd31, 5'd31, 6'h3f, 16'h0004, 26'h3ffffff,
               32'h8fa80004);
    vt[3] = mk(2'd0, 6'h3f, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3f, 16'h0, 26'h0, 32'hffffffff);
    vt[4] = mk(2'd0, 6'h00, 5'd0, 5'd9, 5'd10, 5'd4, 6'h00, 16'hffff, 26'h0, 32'h00095100);
    vt[5] = mk(2'd2, 6'h03, 5'd31, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3ffffff, 32'h0fffffff);
    vt[6] = mk(2'd1, 6'h0f, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h8000, 26'h0, 32'h3c018000);
    zv = mk(2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'd0);
    drive(0, zv, 1'b0, 1'b0);
    drive(1, zv, 1'b0, 1'b0);
    bus0.w_mem_ready = 1'b0;
    bus1.w_mem_ready = 1'b0;

    // Reset values while reset is held.
    @(posedge w_clk);
    #1;
    chk("rst_in_ready", bus0.w_in_ready, 0);
    chk("rst_we", bus0.w_mem_we, 0);
    chk("rst_addr1", bus1.w_mem_addr, 2);
    chk("rst_count", bus0.w_count, 0);
    @(posedge w_clk);
    #1 w_rst = 1'b0;

    // Single I-format word, last.
    bus0.w_mem_ready = 1'b1;
    send(0, mk_i(6'h05, 5'd3, 5'd4, 16'hfffe), 1'b1);
    chk("A_we", bus0.w_mem_we, 1);
    chk("A_wdata", bus0.w_mem_wdata, 32'h1464fffe);
    chk("A_addr", bus0.w_mem_addr, 0);
    chk("A_done_early", bus0.w_done, 0);
    @(posedge w_clk);
    #1;
    chk("A_we_after", bus0.w_mem_we, 0);
    chk("A_count", bus0.w_count, 1);
    chk("A_done", bus0.w_done, 1);

    // Table vectors, back to back.
    do_reset();
    for (int i = 0; i < 7; i++) send(0, vt[i], i == 6);
    wait_done(0, 50, "B_done");
    chk("B_nwrites", cap_n[0], 7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("B_word%0d", i), cap_data[0][i], vt[i].exp);
      chk($sformatf("B_addr%0d", i), cap_addr[0][i], i);
      if (i > 0) chk($sformatf("B_cyc%0d", i), cap_cyc[0][i] - cap_cyc[0][0], i);
    end
    chk("B_count", bus0.w_count, 7);

    // Backpressure: 6 words against a stalled memory.
    do_reset();
    bus0.w_mem_ready = 1'b0;
    acc_n = 0;
    w0 = mk_i(6'h08, 5'd0, 5'd1, 16'd1).exp;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(0, mk_i(6'h08, 5'(i), 5'(i + 1), 16'(i * 3 + 1)), i == 5);
          acc_n++;
        end
      end
      begin
        repeat (8) @(posedge w_clk);
        #1;
        chk("C_ready_low", bus0.w_in_ready, 0);
        chk("C_accepts", acc_n, 4);
        chk("C_head", bus0.w_mem_wdata, w0);
        chk("C_head_addr", bus0.w_mem_addr, 0);
        bus0.w_mem_ready = 1'b1;
      end
    join
    wait_done(0, 100, "C_done");
    chk("C_nwrites", cap_n[0], 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("C_word%0d", i), cap_data[0][i], mk_i(6'h08, 5'(i), 5'(i + 1),
          16'(i * 3 + 1)).exp);
      chk($sformatf("C_addr%0d", i), cap_addr[0][i], i);
    end
    chk("C_count", bus0.w_count, 6);

    // Reserved format in the middle.
    do_reset();
    send(0, mk_i(6'h09, 5'd1, 5'd2, 16'h1234), 1'b0);
    chk("D_err_before", bus0.w_err, 0);
    send(0, mk(2'd3, 6'h3f, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3f, 16'hbeef, 26'h1, 32'd0), 1'b0);
    chk("D_err_set", bus0.w_err, 1);
    send(0, mk_i(6'h09, 5'd3, 5'd4, 16'h5678), 1'b1);
    wait_done(0, 50, "D_done");
    chk("D_nwrites", cap_n[0], 2);
    chk("D_word0", cap_data[0][0], 32'h24221234);
    chk("D_word1", cap_data[0][1], 32'h24645678);
    chk("D_addr1", cap_addr[0][1], 1);
    chk("D_count", bus0.w_count, 2);
    chk("D_err_sticky", bus0.w_err, 1);

    // Address wrap on the narrow instance, then count saturation.
    do_reset();
    bus1.w_mem_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send(1, mk(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'(100 + i), 32'd0), i == 3);
    wait_done(1, 50, "E_done");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("E_addr%0d", i), cap_addr[1][i], (2 + i) % 4);
      chk($sformatf("E_word%0d", i), cap_data[1][i], 32'h08000000 + 32'(100 + i));
    end
    chk("E_count", bus1.w_count, 4);
    do_reset();
    for (int i = 0; i < 9; i++)
      send(1, mk_i(6'h01, 5'd0, 5'd0, 16'(i)), i == 8);
    wait_done(1, 80, "E_done_sat");
    chk("E_count_sat", bus1.w_count, 7);
    chk("E_last_addr", cap_addr[1][8], 2);

    // Reset while draining with words queued.
    do_reset();
    bus0.w_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(0, mk_i(6'h0a, 5'(i), 5'd0, 16'hcafe), i == 2);
    #2 w_rst = 1'b1;
    #1;
    chk("F_we", bus0.w_mem_we, 0);
    chk("F_addr", bus0.w_mem_addr, 0);
    chk("F_wdata", bus0.w_mem_wdata, 0);
    chk("F_in_ready", bus0.w_in_ready, 0);
    repeat (2) @(posedge w_clk);
    #1 w_rst = 1'b0;
    bus0.w_mem_ready = 1'b1;
    repeat (5) begin
      @(negedge w_clk);
      chk("F_no_write", bus0.w_mem_we, 0);
    end
    chk("F_cap", cap_n[0], 0);
    chk("F_ready_again", bus0.w_in_ready, 1);
    @(posedge w_clk);
    #1;

    // Randomized program with memory stalls; the monitor model does the checking.
    do_reset();
    stop = 0;
    nres = 0;
    any_res = 0;
    fork
      while (!stop) begin
        @(posedge w_clk);
        #1 bus0.w_mem_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 120; i++) begin
      vec_t v;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge w_clk);
        #1;
      end
      v = mk(($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)), 6'($urandom),
             5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
             16'($urandom), 26'($urandom), 32'd0);
      if (v.fmt == 2'd3) any_res = 1;
      else nres++;
      send(0, v, i == 119);
    end
    wait_done(0, 1000, "G_done");
    stop = 1;
    chk("G_count", bus0.w_count, nres);
    chk("G_err", bus0.w_err, any_res);
    chk("G_nwrites", cap_n[0], nres);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
